// File: rtl/bank_access_arbiter.sv
// Round-robin arbiter and phase sequencer for one SRAM word bank: grants one of two
// requesters, then walks the bank through decode, word-line-active and precharge recovery.
module bank_access_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned WL_CYCLES  = 2,
  parameter int unsigned PRE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  output logic              ack1,
  output logic [ADDR_W-1:0] sel,
  output logic              wl_en,
  output logic              we_out,
  output logic              precharge,
  output logic              busy,
  output logic              grant_id
);

  // A zero cycle count is treated as one so every phase lasts at least a cycle.
  localparam int unsigned WlEff   = (WL_CYCLES == 0) ? 1 : WL_CYCLES;
  localparam int unsigned PreEff  = (PRE_CYCLES == 0) ? 1 : PRE_CYCLES;
  localparam logic [7:0]  WlLoad  = 8'(WlEff - 1);
  localparam logic [7:0]  PreLoad = 8'(PreEff - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StActive,
    StRecover
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic                we_lat_q;
  logic                rr_ptr_q;
  logic [ADDR_W-1:0]   sel_q;
  logic                wl_en_q;
  logic                we_out_q;
  logic                precharge_q;
  logic                busy_q;
  logic                ack0_q;
  logic                ack1_q;
  logic                grant_id_q;

  logic any_req;
  logic winner;
  logic ack_fire;

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = rr_ptr_q;
    end else begin
      winner = req1;
    end
    // Ack is registered, so raise it on the edge that enters the final recovery cycle.
    ack_fire = ((state_q == StActive) && (cnt_q == 8'd0) && (PreLoad == 8'd0)) ||
               ((state_q == StRecover) && (cnt_q == 8'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      we_lat_q    <= 1'b0;
      rr_ptr_q    <= 1'b0;
      sel_q       <= '0;
      wl_en_q     <= 1'b0;
      we_out_q    <= 1'b0;
      precharge_q <= 1'b1;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      grant_id_q  <= 1'b0;
    end else begin
      ack0_q <= ack_fire & ~grant_id_q;
      ack1_q <= ack_fire & grant_id_q;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q     <= StDecode;
            sel_q       <= winner ? addr1 : addr0;
            we_lat_q    <= winner ? we1 : we0;
            grant_id_q  <= winner;
            rr_ptr_q    <= ~winner;
            busy_q      <= 1'b1;
            precharge_q <= 1'b0;
          end
        end
        StDecode: begin
          state_q  <= StActive;
          cnt_q    <= WlLoad;
          wl_en_q  <= 1'b1;
          we_out_q <= we_lat_q;
        end
        StActive: begin
          if (cnt_q == 8'd0) begin
            state_q     <= StRecover;
            cnt_q       <= PreLoad;
            wl_en_q     <= 1'b0;
            we_out_q    <= 1'b0;
            precharge_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StRecover: begin
          if (cnt_q == 8'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign sel       = sel_q;
  assign wl_en     = wl_en_q;
  assign we_out    = we_out_q;
  assign precharge = precharge_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Bench for bank_access_arbiter: two instances (default timing and WL=4/PRE=3) share stimulus;
// a cycle-arithmetic reference model predicts every output and queues expected acks.
module tb_bank_access_arbiter;

  localparam logic [6:0] IdleCtrl = 7'b0001000;  // {busy,wl,we,pre,ack0,ack1,gid}

  typedef struct {
    int          id;
    logic [9:0]  addr;
    logic        we;
    int          grant;
    int          ack_cyc;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [9:0] addr0 = '0, addr1 = '0;

  logic [1:0] ack0_w, ack1_w, wl_w, weo_w, pre_w, busy_w, gid_w;
  logic [9:0] sel_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         wl_c [2] = '{2, 4};
  int         pre_c [2] = '{1, 3};
  int         nf [2] = '{0, 0};
  bit         rr [2] = '{1'b0, 1'b0};
  bit         cur_v [2] = '{1'b0, 1'b0};
  acc_t       cur [2];
  logic [9:0] last_sel [2] = '{10'h0, 10'h0};
  bit         last_gid [2] = '{1'b0, 1'b0};
  bit         granted [2] = '{1'b0, 1'b0};
  acc_t       sbq0 [$];
  acc_t       sbq1 [$];

  bank_access_arbiter #(.ADDR_W(10), .WL_CYCLES(2), .PRE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .we0(we0), .ack0(ack0_w[0]),
    .req1(req1), .addr1(addr1), .we1(we1), .ack1(ack1_w[0]),
    .sel(sel_w[0]), .wl_en(wl_w[0]), .we_out(weo_w[0]), .precharge(pre_w[0]),
    .busy(busy_w[0]), .grant_id(gid_w[0])
  );

  bank_access_arbiter #(.ADDR_W(10), .WL_CYCLES(4), .PRE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .we0(we0), .ack0(ack0_w[1]),
    .req1(req1), .addr1(addr1), .we1(we1), .ack1(ack1_w[1]),
    .sel(sel_w[1]), .wl_en(wl_w[1]), .we_out(weo_w[1]), .precharge(pre_w[1]),
    .busy(busy_w[1]), .grant_id(gid_w[1])
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] ctrl(input int d);
    return {busy_w[d], wl_w[d], weo_w[d], pre_w[d], ack0_w[d], ack1_w[d], gid_w[d]};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic acc_t qfront(input int d);
    return (d == 0) ? sbq0[0] : sbq1[0];
  endfunction

  task automatic qpop(input int d, output acc_t a);
    if (d == 0) a = sbq0.pop_front();
    else a = sbq1.pop_front();
  endtask

  task automatic flush(input int d);
    if (d == 0) sbq0.delete();
    else sbq1.delete();
    nf[d] = 0;
    rr[d] = 1'b0;
    cur_v[d] = 1'b0;
    last_sel[d] = 10'h0;
    last_gid[d] = 1'b0;
  endtask

  // Reference model: a grant occurs whenever the bank is free and someone requests;
  // every later output is a function of cycles elapsed since that grant.
  task automatic model_step(input int d);
    acc_t a;
    bit   w;
    if (!rst_n) begin
      flush(d);
      return;
    end
    if (cyc >= nf[d] && (req0 || req1)) begin
      w = (req0 && req1) ? rr[d] : req1;
      a.id = w ? 1 : 0;
      a.addr = w ? addr1 : addr0;
      a.we = w ? we1 : we0;
      a.grant = cyc;
      a.ack_cyc = cyc + wl_c[d] + pre_c[d];
      if (d == 0) begin
        sbq0.push_back(a);
        granted[a.id] = 1'b1;
      end else begin
        sbq1.push_back(a);
      end
      cur[d] = a;
      cur_v[d] = 1'b1;
      nf[d] = cyc + wl_c[d] + pre_c[d] + 2;
      rr[d] = !w;
      last_sel[d] = a.addr;
      last_gid[d] = w;
    end
  endtask

  task automatic monitor(input int d);
    int         o;
    bit         ph, wl_e, ack_e, any_ack;
    logic [6:0] exp_v;
    acc_t       a;
    o = cyc - cur[d].grant;
    ph = rst_n && cur_v[d] && (o <= wl_c[d] + pre_c[d]);
    wl_e = ph && (o >= 1) && (o <= wl_c[d]);
    ack_e = ph && (o == wl_c[d] + pre_c[d]);
    exp_v = {ph, wl_e, wl_e && cur[d].we, !(ph && o <= wl_c[d]),
             ack_e && (cur[d].id == 0), ack_e && (cur[d].id == 1), last_gid[d]};
    chk($sformatf("d%0d_ctrl", d), 32'(ctrl(d)), 32'(exp_v));
    chk($sformatf("d%0d_sel", d), 32'(sel_w[d]), 32'(last_sel[d]));
    chk($sformatf("d%0d_ack_excl", d), 32'(ack0_w[d] & ack1_w[d]), 32'd0);
    any_ack = ack0_w[d] | ack1_w[d];
    if (any_ack) begin
      if (qsize(d) == 0) begin
        chk($sformatf("d%0d_unexpected_ack", d), 32'(any_ack), 32'd0);
      end else begin
        qpop(d, a);
        chk($sformatf("d%0d_ack_id", d), 32'(ack1_w[d]), 32'(a.id));
        chk($sformatf("d%0d_ack_cycle", d), 32'(cyc), 32'(a.ack_cyc));
        chk($sformatf("d%0d_ack_sel", d), 32'(sel_w[d]), 32'(a.addr));
      end
    end
    while (qsize(d) > 0 && qfront(d).ack_cyc < cyc) begin
      qpop(d, a);
      chk($sformatf("d%0d_missed_ack", d), 32'(cyc), 32'(a.ack_cyc));
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
  end

  initial forever begin
    @(negedge rst_n);
    flush(0);
    flush(1);
  end

  initial forever begin
    @(negedge clk);
    monitor(0);
    monitor(1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v);
    if (id == 0) req0 = v;
    else req1 = v;
  endtask

  task automatic set_cmd(input int id);
    if (id == 0) begin
      addr0 = 10'($urandom);
      we0 = 1'($urandom);
    end else begin
      addr1 = 10'($urandom);
      we1 = 1'($urandom);
    end
  endtask

  task automatic wait_ack(input int d, input int id, input int bound, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      hit = (id == 1) ? ack1_w[d] : ack0_w[d];
    end
    chk($sformatf("ack_wait_d%0d_r%0d", d, id), 32'(hit), 32'd1);
  endtask

  task automatic requester(input int id, input int iters);
    bit renew;
    bit hit;
    int n;
    renew = 1'b0;
    for (int i = 0; i < iters; i++) begin
      if (!renew) begin
        set_req(id, 1'b0);
        repeat ($urandom_range(0, 4)) tick();
      end
      set_req(id, 1'b1);
      set_cmd(id);
      granted[id] = 1'b0;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 60) begin
        @(negedge clk);
        n++;
        hit = (id == 1) ? ack1_w[0] : ack0_w[0];
        if (!hit) begin
          tick();
          if ($urandom_range(0, 5) == 0) set_cmd(id);
          if (granted[id] && $urandom_range(0, 7) == 0) set_req(id, 1'b0);
        end
      end
      chk($sformatf("rand_ack_wait_r%0d", id), 32'(hit), 32'd1);
      tick();
      renew = 1'($urandom_range(0, 1));
    end
    set_req(id, 1'b0);
  endtask

  initial begin
    int n, wlc, cycles, extra;
    bit we_seen;
    logic [9:0] exp_sel [3];
    int exp_id [3];

    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", 32'(ctrl(0)), 32'(IdleCtrl));
    chk("reset_sel", 32'(sel_w[0]), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single write on the default instance.
    req0 = 1'b1; addr0 = 10'h2A5; we0 = 1'b1;
    @(negedge clk);
    chk("sw_idle_before_grant", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    chk("sw_decode_ctrl", 32'(ctrl(0)), 32'h40);
    chk("sw_decode_sel", 32'(sel_w[0]), 32'h2A5);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("sw_active_ctrl", 32'(ctrl(0)), 32'h70);
    end
    @(negedge clk);
    chk("sw_recover_ctrl", 32'(ctrl(0)), 32'h4C);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("sw_done_ctrl", 32'(ctrl(0)), 32'(IdleCtrl));
    repeat (12) tick();

    // Contention from reset: expect 0, 1, 0 at 5-cycle spacing.
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'h001; addr1 = 10'h3FF; we0 = 1'b0; we1 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    exp_id = '{0, 1, 0};
    exp_sel = '{10'h001, 10'h3FF, 10'h001};
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(ack0_w[0] || ack1_w[0]) && n < 20);
      chk("cont_id", 32'(ack1_w[0]), 32'(exp_id[k]));
      chk("cont_sel", 32'(sel_w[0]), 32'(exp_sel[k]));
      if (k > 0) chk("cont_period", 32'(n), 32'd5);
      tick();
      if (k == 1) req1 = 1'b0;
      if (k == 2) req0 = 1'b0;
    end
    repeat (12) tick();

    // Long-timing instance: single read at address 0.
    req0 = 1'b1; addr0 = 10'h000; we0 = 1'b0;
    n = 0;
    while (!busy_w[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_busy", 32'(busy_w[1]), 32'd1);
    wlc = 0; cycles = 0; we_seen = 1'b0;
    while (!ack0_w[1] && cycles < 20) begin
      @(negedge clk);
      cycles++;
      wlc += int'(wl_w[1]);
      we_seen |= weo_w[1];
    end
    chk("sweep_wl_cycles", 32'(wlc), 32'd4);
    chk("sweep_ack_latency", 32'(cycles), 32'd7);
    chk("sweep_we_out", 32'(we_seen), 32'd0);
    tick();
    req0 = 1'b0;
    repeat (12) tick();

    // Address change after grant is ignored.
    req1 = 1'b1; addr1 = 10'h155; we1 = 1'b0;
    tick();
    tick();
    addr1 = 10'h0AA;
    wait_ack(0, 1, 20, n);
    chk("addr_change_sel", 32'(sel_w[0]), 32'h155);
    tick();
    req1 = 1'b0;
    repeat (12) tick();

    // Reset during ACTIVE: outputs return to idle without a clock edge.
    req0 = 1'b1; addr0 = 10'h123; we0 = 1'b1;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'(ctrl(0)), 32'(IdleCtrl));
    chk("rst_mid_sel", 32'(sel_w[0]), 32'd0);
    chk("rst_mid_ctrl_d1", 32'(ctrl(1)), 32'(IdleCtrl));
    req0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      extra += int'(ack0_w[0]);
    end
    chk("rst_mid_no_ack", 32'(extra), 32'd0);
    tick();
    req0 = 1'b1; addr0 = 10'h3C3; we0 = 1'b0;
    wait_ack(0, 0, 20, n);
    chk("rst_after_sel", 32'(sel_w[0]), 32'h3C3);
    tick();
    req0 = 1'b0;
    repeat (12) tick();

    // Early drop during DECODE still completes with one ack.
    req1 = 1'b1; addr1 = 10'h02B; we1 = 1'b0;
    tick();
    req1 = 1'b0;
    wait_ack(0, 1, 20, n);
    tick();
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      extra += int'(ack1_w[0]);
    end
    chk("early_drop_extra_ack", 32'(extra), 32'd0);
    chk("early_drop_idle", 32'(busy_w[0]), 32'd0);
    tick();

    // Randomised phase.
    fork
      requester(0, 150);
      requester(1, 150);
    join
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (20) tick();
    chk("sb_empty_d0", 32'(sbq0.size()), 32'd0);
    chk("sb_empty_d1", 32'(sbq1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
